// File: rtl/serial_adder_sequencer.sv
// Bit-serial WIDTH-bit adder: one full_adder reused LSB-first, result after WIDTH RUN cycles.
// Operands and results use valid/ready handshakes; the result is held in DONE until out_ready is high.
`timescale 1ns/1ps

module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);
endmodule

module serial_adder_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_carry_q;
  logic             fa_sum, fa_cout;
  logic             accept, last_bit;

  full_adder u_fa (
    .a         (a_sh[0]),
    .b         (b_sh[0]),
    .carry_in  (carry_q),
    .sum       (fa_sum),
    .carry_out (fa_cout)
  );

  // Ripple increment built from XOR/AND so the full_adder stays the only adder.
  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          c;
    c = 1'b1;
    for (int i = 0; i < CW; i++) begin
      r[i] = v[i] ^ c;
      c    = c & v[i];
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign last_bit = (state == RUN) && (cnt == LAST);

  always_comb begin
    sum_nxt            = sum_sh >> 1;
    sum_nxt[WIDTH-1]   = fa_sum;
  end

  // Operands are sampled only on accept, so junk on in_a/in_b while idle never reaches state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      carry_q     <= 1'b0;
      cnt         <= '0;
      out_sum_q   <= '0;
      out_carry_q <= 1'b0;
    end else if (accept) begin
      a_sh    <= in_a;
      b_sh    <= in_b;
      carry_q <= in_carry;
      sum_sh  <= '0;
      cnt     <= '0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      sum_sh  <= sum_nxt;
      carry_q <= fa_cout;
      cnt     <= cnt_inc(cnt);
      if (last_bit) begin
        out_sum_q   <= sum_nxt;
        out_carry_q <= fa_cout;
      end
    end
  end

  // Result registers only move on the final bit, so they hold the last result outside DONE.
  assign out_sum   = out_sum_q;
  assign out_carry = out_carry_q;

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_sum) && $stable(out_carry)));

  a_no_accept_busy: assert property (@(posedge clk) disable iff (!rst_n)
    busy |-> !in_ready);

endmodule

// File: tb/tb_serial_adder_sequencer.sv
// Bench for serial_adder_sequencer: WIDTH=8 and WIDTH=1 instances against a cycle-count reference model.
`timescale 1ns/1ps

module tb_serial_adder_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       v8, r8, ov8, or8, oc8, busy8, cin8;
  logic [7:0] a8, b8, os8;
  logic       v1, r1, ov1, or1, oc1, busy1, cin1;
  logic [0:0] a1, b1, os1;

  serial_adder_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_a(a8), .in_b(b8),
    .in_carry(cin8), .out_valid(ov8), .out_ready(or8), .out_sum(os8), .out_carry(oc8), .busy(busy8)
  );

  serial_adder_sequencer #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_a(a1), .in_b(b1),
    .in_carry(cin1), .out_valid(ov1), .out_ready(or1), .out_sum(os1), .out_carry(oc1), .busy(busy1)
  );

  // Model: phase 0 waiting, 1 computing (timer counts down WIDTH cycles), 2 result offered.
  typedef struct {
    int          phase;
    int          timer;
    logic [32:0] res;
    logic [31:0] sum;
    logic        carry;
  } mdl_t;

  mdl_t m8, m1;
  int   checks = 0;
  int   errors = 0;

  function automatic mdl_t mdl_zero();
    mdl_t n;
    n.phase = 0; n.timer = 0; n.res = '0; n.sum = '0; n.carry = 1'b0;
    return n;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input int w, input logic vld,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, input logic ordy);
    mdl_t        n;
    logic [32:0] mask;
    n    = m;
    mask = (33'd1 << w) - 33'd1;
    case (m.phase)
      0: if (vld) begin
        n.res   = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 33'(cin);
        n.timer = w;
        n.phase = 1;
      end
      1: begin
        n.timer = m.timer - 1;
        if (n.timer == 0) begin
          n.phase = 2;
          n.sum   = 32'(n.res & mask);
          n.carry = n.res[w];
        end
      end
      2: if (ordy) n.phase = 0;
      default: n.phase = 0;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8 <= mdl_zero();
      m1 <= mdl_zero();
    end else begin
      m8 <= mdl_step(m8, 8, v8, 32'(a8), 32'(b8), cin8, or8);
      m1 <= mdl_step(m1, 1, v1, 32'(a1), 32'(b1), cin1, or1);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("m_vld8",  32'(ov8),   32'(m8.phase == 2));
      chk("m_rdy8",  32'(r8),    32'(m8.phase == 0));
      chk("m_busy8", 32'(busy8), 32'(m8.phase != 0));
      chk("m_sum8",  32'(os8),   32'(m8.sum[7:0]));
      chk("m_co8",   32'(oc8),   32'(m8.carry));
      chk("m_vld1",  32'(ov1),   32'(m1.phase == 2));
      chk("m_rdy1",  32'(r1),    32'(m1.phase == 0));
      chk("m_busy1", 32'(busy1), 32'(m1.phase != 0));
      chk("m_sum1",  32'(os1),   32'(m1.sum[0]));
      chk("m_co1",   32'(oc1),   32'(m1.carry));
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic [7:0] es, input logic ec, input int hold);
    int lat;
    @(negedge clk);
    v8 = 1'b1; a8 = a; b8 = b; cin8 = cin; or8 = (hold == 0);
    @(posedge clk); #1;
    chk("accept8", 32'(busy8), 32'd1);
    @(negedge clk);
    v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = 0;
    while (!ov8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("lat8", 32'(lat), 32'd8);
    chk("sum8_lit", 32'(os8), 32'(es));
    chk("co8_lit", 32'(oc8), 32'(ec));
    chk("mdl_sum8", m8.sum, 32'(es));
    chk("mdl_co8", 32'(m8.carry), 32'(ec));
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        v8 = 1'($urandom); a8 = 8'($urandom);
        @(posedge clk); #1;
        chk("hold_sum", 32'(os8), 32'(es));
        chk("hold_rdy", 32'(r8), 32'd0);
        chk("hold_busy", 32'(busy8), 32'd1);
        chk("hold_vld", 32'(ov8), 32'd1);
      end
      @(negedge clk);
      v8 = 1'b0; or8 = 1'b1;
    end
    @(posedge clk); #1;
    chk("retire_vld", 32'(ov8), 32'd0);
    chk("retire_rdy", 32'(r8), 32'd1);
  endtask

  task automatic op1(input logic a, input logic b, input logic cin);
    logic [1:0] exp;
    exp = 2'(a) + 2'(b) + 2'(cin);
    @(negedge clk);
    v1 = 1'b1; a1 = a; b1 = b; cin1 = cin; or1 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    v1 = 1'b0;
    @(posedge clk); #1;
    chk("lat1", 32'(ov1), 32'd1);
    chk("res1", 32'({oc1, os1}), 32'(exp));
    @(posedge clk); #1;
    chk("retire1", 32'(ov1), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    v8 = 1'b1; a8 = 8'hC3; b8 = 8'h5A; cin8 = 1'b1; or8 = 1'b1;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; or1 = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_vld", 32'(ov8), 32'd0);
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_rdy", 32'(r8), 32'd1);
      chk("rst_sum", 32'(os8), 32'd0);
      chk("rst_co", 32'(oc8), 32'd0);
    end
    @(negedge clk);
    v8 = 1'b0; v1 = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("no_capture", 32'(busy8), 32'd0);

    op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0);
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);
    op8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 5);
    op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1(v[2], v[1], v[0]);
    end

    // Free-running random traffic; the compare process does the checking.
    repeat (600) begin
      @(negedge clk);
      v8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      or8 = ($urandom_range(0, 3) != 0);
      v1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      or1 = 1'($urandom);
    end
    @(negedge clk);
    v8 = 1'b0; or8 = 1'b1; v1 = 1'b0; or1 = 1'b1;
    repeat (12) @(posedge clk);

    // Asynchronous reset in the middle of a computation.
    @(negedge clk);
    v8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    v8 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(ov8), 32'd0);
    chk("mid_rst_sum", 32'(os8), 32'd0);
    chk("mid_rst_busy", 32'(busy8), 32'd0);
    chk("mid_rst_rdy", 32'(r8), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
